// File: rtl/pc_trace_buffer.sv
// Instruction trace recorder: captures {PC, IR} of retired instructions into a
// circular buffer, optionally freezes after a PC-match trigger, then drains.
module pc_trace_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IR_W  = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cap_valid,
  input  logic [PC_W-1:0]          cap_pc,
  input  logic [IR_W-1:0]          cap_ir,
  input  logic                     mode,
  input  logic                     trig_en,
  input  logic [PC_W-1:0]          trig_pc,
  input  logic [CNT_W-1:0]         post_cnt,
  input  logic                     arm,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [IR_W-1:0]          rd_ir,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               state,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0] FULL_M1 = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ARMED  = 2'b01,
    S_TRIG   = 2'b10,
    S_FROZEN = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              ovf_q, ovf_d;
  logic              mem_we;
  logic              capturing;
  logic              full;
  logic              pop;

  logic [PC_W+IR_W-1:0] mem_q [DEPTH];

  assign capturing = ((state_q == S_ARMED) || (state_q == S_TRIG)) && cap_valid && !arm;
  assign full      = (count_q == FULL);
  assign rd_valid  = (state_q == S_FROZEN) && (count_q != '0);
  assign pop       = rd_valid && rd_ready;

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rem_d    = rem_q;
    ovf_d    = ovf_q;
    mem_we   = 1'b0;
    if (arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (capturing) begin
      if (full && !mode) begin
        // Only reachable if mode flips to 0 while already full: entry is dropped.
        ovf_d = 1'b1;
      end else begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (full) begin
          rd_ptr_d = rd_ptr_q + 1'b1;
          ovf_d    = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
        if ((state_q == S_ARMED) && trig_en && (cap_pc == trig_pc)) begin
          rem_d   = post_cnt;
          state_d = (post_cnt == '0) ? S_FROZEN : S_TRIG;
        end else if (state_q == S_TRIG) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_FROZEN;
        end
        if (!mode && (count_q == FULL_M1)) state_d = S_FROZEN;
      end
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rem_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= {cap_pc, cap_ir};
  end

  assign rd_pc    = rd_valid ? mem_q[rd_ptr_q][PC_W+IR_W-1:IR_W] : '0;
  assign rd_ir    = rd_valid ? mem_q[rd_ptr_q][IR_W-1:0] : '0;
  assign count    = count_q;
  assign state    = state_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pc_trace_buffer.sv
// Scoreboard bench for pc_trace_buffer: queue-based reference model, directed
// scenarios followed by randomized traffic.
module tb_pc_trace_buffer;

  localparam int DEPTH = 16;
  localparam int PC_W  = 32;
  localparam int IR_W  = 32;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cap_valid;
  logic [PC_W-1:0]  cap_pc;
  logic [IR_W-1:0]  cap_ir;
  logic             mode;
  logic             trig_en;
  logic [PC_W-1:0]  trig_pc;
  logic [CNT_W-1:0] post_cnt;
  logic             arm;
  logic             rd_ready;
  logic             rd_valid;
  logic [PC_W-1:0]  rd_pc;
  logic [IR_W-1:0]  rd_ir;
  logic [4:0]       count;
  logic [1:0]       state;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  pc_trace_buffer #(.DEPTH(DEPTH), .PC_W(PC_W), .IR_W(IR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_ir(cap_ir),
    .mode(mode), .trig_en(trig_en), .trig_pc(trig_pc), .post_cnt(post_cnt),
    .arm(arm), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_ir(rd_ir),
    .count(count), .state(state), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: trace kept as a plain queue of entries.
  typedef struct { logic [PC_W-1:0] pc; logic [IR_W-1:0] ir; } ent_t;
  ent_t m_q[$];
  ent_t exp_q[$];
  int   m_state;
  int   m_rem;
  bit   m_ovf;

  always @(posedge clk or negedge rst) begin : model
    ent_t e;
    bit   stored;
    if (!rst) begin
      m_q.delete(); exp_q.delete();
      m_state = 0; m_rem = 0; m_ovf = 0;
    end else if (arm) begin
      m_q.delete(); exp_q.delete();
      m_state = 1; m_ovf = 0;
    end else if ((m_state == 1 || m_state == 2) && cap_valid) begin
      e.pc = cap_pc; e.ir = cap_ir;
      stored = 1;
      if (m_q.size() == DEPTH) begin
        m_ovf = 1;
        if (mode) void'(m_q.pop_front());
        else stored = 0;
      end
      if (stored) begin
        m_q.push_back(e);
        if (m_state == 1 && trig_en && cap_pc == trig_pc) begin
          m_rem   = int'(post_cnt);
          m_state = (m_rem == 0) ? 3 : 2;
        end else if (m_state == 2) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) m_state = 3;
        end
        if (!mode && m_q.size() == DEPTH) m_state = 3;
        if (m_state == 3) exp_q = m_q;
      end
    end else if (m_state == 3 && rd_ready && m_q.size() > 0) begin
      void'(m_q.pop_front());
    end
  end

  // Monitor: status vs model every cycle, read port vs expected-entry queue.
  always @(negedge clk) begin
    if (rst) begin
      check("state", 64'(state), 64'(m_state));
      check("count", 64'(count), 64'(m_q.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("rd_valid", 64'(rd_valid), 64'(m_state == 3 && m_q.size() > 0));
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got pc %0h with no entry expected", rd_pc);
        end else begin
          check("rd_pc", 64'(rd_pc), 64'(exp_q[0].pc));
          check("rd_ir", 64'(rd_ir), 64'(exp_q[0].ir));
          if (rd_ready) void'(exp_q.pop_front());
        end
      end else begin
        check("rd_pc_gated", 64'(rd_pc), 64'd0);
        check("rd_ir_gated", 64'(rd_ir), 64'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic capture(input logic [PC_W-1:0] pc);
    cap_valid = 1'b1; cap_pc = pc; cap_ir = $urandom; tick(); cap_valid = 1'b0;
  endtask

  task automatic drain(input int cycles);
    rd_ready = 1'b1;
    repeat (cycles) tick();
    rd_ready = 1'b0;
    check("drain_count", 64'(count), 64'd0);
    check("drain_all_seen", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b0; cap_valid = 1'b0; cap_pc = '0; cap_ir = '0; mode = 1'b0;
    trig_en = 1'b0; trig_pc = '0; post_cnt = '0; arm = 1'b0; rd_ready = 1'b0;
    #1;
    check("reset_state", 64'(state), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();

    // Stop-when-full
    mode = 1'b0; trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) capture(32'(i * 4));
    check("t2_frozen", 64'(state), 64'd3);
    check("t2_count", 64'(count), 64'd16);
    check("t2_ovf", 64'(overflow), 64'd0);
    drain(20);

    // Wrap, then trigger with post_cnt=0
    mode = 1'b1; trig_en = 1'b0;
    do_arm();
    for (int i = 0; i < 20; i++) capture(32'(i * 4));
    check("t3_armed", 64'(state), 64'd1);
    check("t3_count", 64'(count), 64'd16);
    check("t3_ovf", 64'(overflow), 64'd1);
    trig_pc = 32'h50; trig_en = 1'b1; post_cnt = '0;
    capture(32'h50);
    check("t3_frozen", 64'(state), 64'd3);
    check("t3_oldest", 64'(rd_pc), 64'h14);
    drain(20);

    // Trigger with post_cnt=3
    mode = 1'b1; trig_en = 1'b1; trig_pc = 32'h20; post_cnt = 8'd3;
    do_arm();
    for (int i = 0; i < 16; i++) capture(32'(i * 4));
    check("t4_frozen", 64'(state), 64'd3);
    check("t4_count", 64'(count), 64'd12);
    check("t4_oldest", 64'(rd_valid), 64'd1);
    drain(16);

    // Arm collides with a capture
    trig_en = 1'b0;
    do_arm();
    capture(32'h4); capture(32'h8);
    arm = 1'b1; cap_valid = 1'b1; cap_pc = 32'hC;
    tick();
    arm = 1'b0; cap_valid = 1'b0;
    check("t5_count", 64'(count), 64'd0);
    check("t5_state", 64'(state), 64'd1);

    // Backpressure on a 4-entry frozen trace
    trig_en = 1'b1; trig_pc = 32'h100; post_cnt = 8'd3;
    do_arm();
    for (int i = 0; i < 6; i++) capture(32'h100 + 32'(i * 4));
    check("t6_count", 64'(count), 64'd4);
    for (int i = 0; i < 10; i++) begin
      rd_ready = (i % 2 == 0);
      tick();
    end
    rd_ready = 1'b0;
    check("t6_empty", 64'(rd_valid), 64'd0);
    check("t6_left", 64'(exp_q.size()), 64'd0);

    // Reset mid-drain
    do_arm();
    for (int i = 0; i < 4; i++) capture(32'h100 + 32'(i * 4));
    rd_ready = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    check("t1_state", 64'(state), 64'd0);
    check("t1_count", 64'(count), 64'd0);
    check("t1_rd_valid", 64'(rd_valid), 64'd0);
    check("t1_rd_pc", 64'(rd_pc), 64'd0);
    check("t1_ovf", 64'(overflow), 64'd0);
    rd_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      arm       = ($urandom_range(0, 59) == 0);
      cap_valid = ($urandom_range(0, 2) != 0);
      cap_pc    = 32'($urandom_range(0, 23) * 4);
      cap_ir    = $urandom;
      rd_ready  = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) mode = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 49) == 0) trig_en = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 49) == 0) trig_pc = 32'($urandom_range(0, 23) * 4);
      if ($urandom_range(0, 49) == 0) post_cnt = 8'($urandom_range(0, 6));
      tick();
    end
    arm = 1'b0; cap_valid = 1'b0; rd_ready = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
